// File: rtl/nubus_master_sched.sv
// nubus_master_sched: shares the card's single NuBus master engine between
// the CPU (port 0) and local DMA (port 1). Encodes byte strobes into NuBus
// transfer mode and address low bits, issues via mst_req/mst_done, retries
// "try again later" a bounded number of times and returns data or error.
// Optional watchdog abort: define NUBUS_SCHED_WATCHDOG_EN.
module nubus_master_sched #(
  parameter int unsigned MAX_RETRY   = 4,
  parameter int unsigned RETRY_DELAY = 8,
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic        nub_clkn,
  input  logic        nub_resetn,
  input  logic        r0_valid,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_wstrb,
  input  logic        r0_lock,
  output logic        r0_ready,
  output logic        r0_err,
  output logic [31:0] r0_rdata,
  input  logic        r1_valid,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_wstrb,
  input  logic        r1_lock,
  output logic        r1_ready,
  output logic        r1_err,
  output logic [31:0] r1_rdata,
  output logic        mst_req,
  output logic [31:0] mst_addr,
  output logic [31:0] mst_wdata,
  output logic        mst_tm1n,
  output logic        mst_tm0n,
  output logic        mst_lock,
  output logic        mst_abort,
  input  logic        mst_done,
  input  logic [1:0]  mst_status,
  input  logic [31:0] mst_rdata,
  output logic [1:0]  sched_owner
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_EVAL    = 3'd2;
  localparam logic [2:0] ST_BACKOFF = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  localparam logic [3:0] RETRY_MAX  = MAX_RETRY[3:0];
  localparam logic [7:0] DELAY_LAST = 8'(RETRY_DELAY - 1);

  logic [2:0]  state;
  logic        rr_ptr;
  logic        lock_held;
  logic        lock_port;
  logic        cur_port;
  logic        cur_read;
  logic        resp_err;
  logic [3:0]  retry_cnt;
  logic [7:0]  delay_cnt;
  logic [1:0]  status_q;
  logic [31:0] rdata_q;

`ifdef NUBUS_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  logic        gnt_valid;
  logic        gnt_port;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_lock;
  logic        enc_legal;
  logic        enc_tm1n;
  logic        enc_tm0n;
  logic [1:0]  enc_low;

  // Grant selection: a held lock wins while its owner is valid, else round-robin.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = 1'b0;
    if (lock_held && (lock_port ? r1_valid : r0_valid)) begin
      gnt_valid = 1'b1;
      gnt_port  = lock_port;
    end else if (rr_ptr ? r1_valid : r0_valid) begin
      gnt_valid = 1'b1;
      gnt_port  = rr_ptr;
    end else if (rr_ptr ? r0_valid : r1_valid) begin
      gnt_valid = 1'b1;
      gnt_port  = ~rr_ptr;
    end
    sel_addr  = gnt_port ? r1_addr  : r0_addr;
    sel_wdata = gnt_port ? r1_wdata : r0_wdata;
    sel_wstrb = gnt_port ? r1_wstrb : r0_wstrb;
    sel_lock  = gnt_port ? r1_lock  : r0_lock;
  end

  // Strobe to NuBus transfer mode and address low bits.
  always_comb begin
    enc_legal = 1'b1;
    enc_tm1n  = 1'b0;
    enc_tm0n  = 1'b1;
    enc_low   = 2'b00;
    case (sel_wstrb)
      4'b0000: enc_tm1n = 1'b1;
      4'b1111: enc_low  = 2'b00;
      4'b0011: enc_low  = 2'b01;
      4'b1100: enc_low  = 2'b11;
      4'b0001: begin enc_tm0n = 1'b0; enc_low = 2'b00; end
      4'b0010: begin enc_tm0n = 1'b0; enc_low = 2'b01; end
      4'b0100: begin enc_tm0n = 1'b0; enc_low = 2'b10; end
      4'b1000: begin enc_tm0n = 1'b0; enc_low = 2'b11; end
      default: enc_legal = 1'b0;
    endcase
  end

`ifndef NUBUS_SCHED_WATCHDOG_EN
  assign mst_abort = 1'b0;
`endif

  // Scheduler FSM, issue handshake, retry backoff and response pulses.
  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      lock_held   <= 1'b0;
      lock_port   <= 1'b0;
      cur_port    <= 1'b0;
      cur_read    <= 1'b0;
      resp_err    <= 1'b0;
      retry_cnt   <= '0;
      delay_cnt   <= '0;
      status_q    <= '0;
      rdata_q     <= '0;
      r0_ready    <= 1'b0;
      r1_ready    <= 1'b0;
      r0_err      <= 1'b0;
      r1_err      <= 1'b0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
      mst_req     <= 1'b0;
      mst_addr    <= '0;
      mst_wdata   <= '0;
      mst_tm1n    <= 1'b1;
      mst_tm0n    <= 1'b1;
      mst_lock    <= 1'b0;
      sched_owner <= '0;
`ifdef NUBUS_SCHED_WATCHDOG_EN
      mst_abort   <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      r0_ready <= 1'b0;
      r1_ready <= 1'b0;
      r0_err   <= 1'b0;
      r1_err   <= 1'b0;
`ifdef NUBUS_SCHED_WATCHDOG_EN
      mst_abort <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            rr_ptr      <= ~gnt_port;
            cur_port    <= gnt_port;
            sched_owner <= gnt_port ? 2'b10 : 2'b01;
            mst_lock    <= sel_lock;
            lock_held   <= sel_lock;
            lock_port   <= gnt_port;
            cur_read    <= (sel_wstrb == 4'b0000);
            if (enc_legal) begin
              // full-width mask keeps every address bit in the expression
              mst_addr  <= (sel_addr & 32'hFFFF_FFFC) | {30'd0, enc_low};
              mst_wdata <= sel_wdata;
              mst_tm1n  <= enc_tm1n;
              mst_tm0n  <= enc_tm0n;
              mst_req   <= 1'b1;
              resp_err  <= 1'b0;
              state     <= ST_ISSUE;
`ifdef NUBUS_SCHED_WATCHDOG_EN
              wd_cnt    <= '0;
`endif
            end else begin
              resp_err <= 1'b1;
              state    <= ST_RESP;
            end
          end else if (lock_held) begin
            lock_held <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (mst_done) begin
            mst_req  <= 1'b0;
            status_q <= mst_status;
            rdata_q  <= mst_rdata;
            state    <= ST_EVAL;
`ifdef NUBUS_SCHED_WATCHDOG_EN
          end else if (wd_cnt == WD_LAST) begin
            mst_req   <= 1'b0;
            mst_abort <= 1'b1;
            resp_err  <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        ST_EVAL: begin
          case (status_q)
            2'b00: begin resp_err <= 1'b0; state <= ST_RESP; end
            2'b11: begin
              if (retry_cnt < RETRY_MAX) begin
                retry_cnt <= retry_cnt + 4'd1;
                delay_cnt <= '0;
                state     <= ST_BACKOFF;
              end else begin
                resp_err <= 1'b1;
                state    <= ST_RESP;
              end
            end
            default: begin resp_err <= 1'b1; state <= ST_RESP; end
          endcase
        end
        ST_BACKOFF: begin
          if (delay_cnt == DELAY_LAST) begin
            delay_cnt <= '0;
            mst_req   <= 1'b1;
            state     <= ST_ISSUE;
`ifdef NUBUS_SCHED_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
          end else begin
            delay_cnt <= delay_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (cur_port) begin
            r1_ready <= 1'b1;
            r1_err   <= resp_err;
            if (!resp_err && cur_read) r1_rdata <= rdata_q;
          end else begin
            r0_ready <= 1'b1;
            r0_err   <= resp_err;
            if (!resp_err && cur_read) r0_rdata <= rdata_q;
          end
          retry_cnt   <= '0;
          sched_owner <= '0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nubus_master_sched.sv
// Testbench for nubus_master_sched: directed steps plus randomized traffic
// checked against a transaction-level model of arbitration, encoding and data.
module tb_nubus_master_sched;
  localparam int unsigned MAX_RETRY   = 4;
  localparam int unsigned RETRY_DELAY = 8;
  localparam int unsigned WDOG_CYCLES = 16;

  logic        nub_clkn = 1'b1;
  logic        nub_resetn = 1'b0;
  logic [1:0]  rv = '0;
  logic [1:0]  rlock = '0;
  logic [31:0] raddr [2];
  logic [31:0] rwdata [2];
  logic [3:0]  rwstrb [2];
  logic        r0_ready, r1_ready, r0_err, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mst_req, mst_tm1n, mst_tm0n, mst_lock, mst_abort;
  logic [31:0] mst_addr, mst_wdata;
  logic        mst_done = 1'b0;
  logic [1:0]  mst_status = '0;
  logic [31:0] mst_rdata = '0;
  logic [1:0]  sched_owner;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int          last_w = 1;
  bit          lk_held = 1'b0;
  int          lk_port = 0;
  logic [31:0] mrd [2];

  nubus_master_sched #(
    .MAX_RETRY(MAX_RETRY), .RETRY_DELAY(RETRY_DELAY), .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn),
    .r0_valid(rv[0]), .r0_addr(raddr[0]), .r0_wdata(rwdata[0]), .r0_wstrb(rwstrb[0]),
    .r0_lock(rlock[0]), .r0_ready(r0_ready), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_valid(rv[1]), .r1_addr(raddr[1]), .r1_wdata(rwdata[1]), .r1_wstrb(rwstrb[1]),
    .r1_lock(rlock[1]), .r1_ready(r1_ready), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mst_req(mst_req), .mst_addr(mst_addr), .mst_wdata(mst_wdata),
    .mst_tm1n(mst_tm1n), .mst_tm0n(mst_tm0n), .mst_lock(mst_lock), .mst_abort(mst_abort),
    .mst_done(mst_done), .mst_status(mst_status), .mst_rdata(mst_rdata),
    .sched_owner(sched_owner)
  );

  always #5 nub_clkn = ~nub_clkn;

  // Lands mid-cycle, just past the next active (falling) edge.
  task automatic tick();
    @(posedge nub_clkn);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {legal, tm1n, tm0n, low[1:0]} from strobe population and position
  function automatic logic [4:0] enc_model(input logic [3:0] s);
    int n = 0;
    int k = -1;
    for (int i = 0; i < 4; i++) if (s[i]) begin n++; if (k < 0) k = i; end
    if (n == 0) return 5'b11100;
    if (n == 4) return 5'b10100;
    if (n == 1) return {3'b100, 2'(k)};
    if (n == 2 && (k % 2) == 0 && s[k+1]) return {3'b101, 2'(k + 1)};
    return 5'b00000;
  endfunction

  function automatic int predict();
    int pref;
    if (lk_held && rv[lk_port]) return lk_port;
    pref = 1 - last_w;
    if (rv[pref]) return pref;
    return 1 - pref;
  endfunction

  task automatic new_req(input int p, input logic [31:0] a, input logic [3:0] s, input logic l);
    raddr[p]  = a;
    rwdata[p] = $urandom;
    rwstrb[p] = s;
    rlock[p]  = l;
    rv[p]     = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
    if (!rv[lk_port]) lk_held = 1'b0;
  endtask

  // One full transaction: grant, encoding, done handshake, response.
  task automatic xact(input logic [1:0] st, input logic [31:0] rd);
    int w;
    logic [4:0] e;
    logic [1:0] eo;
    logic eerr;
    w  = predict();
    e  = enc_model(rwstrb[w]);
    eo = (w == 0) ? 2'b01 : 2'b10;
    tick();
    check("grant_owner", sched_owner, eo);
    last_w = w;
    lk_held = rlock[w];
    lk_port = w;
    if (e[4]) begin
      check("req_up", mst_req, 1);
      check("mst_addr", mst_addr, {raddr[w][31:2], e[1:0]});
      check("tm1n", mst_tm1n, e[3]);
      check("tm0n", mst_tm0n, e[2]);
      check("mst_wdata", mst_wdata, rwdata[w]);
      check("mst_lock", mst_lock, rlock[w]);
      repeat ($urandom_range(0, 3)) begin tick(); check("req_hold", mst_req, 1); end
      mst_done = 1'b1; mst_status = st; mst_rdata = rd;
      tick();
      mst_done = 1'b0; mst_status = 2'($urandom); mst_rdata = $urandom;
      check("req_drop", mst_req, 0);
      tick();
      check("ready_early", {r1_ready, r0_ready}, 0);
      check("owner_hold", sched_owner, eo);
      if (st == 2'b00 && rwstrb[w] == 4'b0000) mrd[w] = rd;
      eerr = (st != 2'b00);
    end else begin
      check("illegal_noreq", mst_req, 0);
      eerr = 1'b1;
    end
    tick();
    check("ready", {r1_ready, r0_ready}, eo);
    check("err", (w == 0) ? r0_err : r1_err, eerr);
    check("rdata0", r0_rdata, mrd[0]);
    check("rdata1", r1_rdata, mrd[1]);
  endtask

  initial begin
    int gap;
    int bad;
    mrd[0] = '0; mrd[1] = '0;
    for (int p = 0; p < 2; p++) begin raddr[p] = '0; rwdata[p] = '0; rwstrb[p] = '0; end

    // reset state
    tick(); tick();
    check("rst_ready", {r1_ready, r0_ready}, 0);
    check("rst_err", {r1_err, r0_err}, 0);
    check("rst_req", mst_req, 0);
    check("rst_lock", mst_lock, 0);
    check("rst_abort", mst_abort, 0);
    check("rst_rdata0", r0_rdata, 0);
    check("rst_rdata1", r1_rdata, 0);
    check("rst_addr", mst_addr, 0);
    check("rst_wdata", mst_wdata, 0);
    check("rst_tm", {mst_tm1n, mst_tm0n}, 2'b11);
    check("rst_owner", sched_owner, 0);
    nub_resetn = 1'b1;
    idle(2);

    // r0 read
    new_req(0, 32'hF500_0010, 4'b0000, 1'b0);
    xact(2'b00, 32'hDEAD_BEEF);
    rv[0] = 1'b0;
    idle(1);

    // r1 byte write lane 2, upper halfword write, illegal strobe
    new_req(1, 32'hF500_0020, 4'b0100, 1'b0);
    xact(2'b00, 32'h0);
    new_req(1, 32'hF500_0024, 4'b1100, 1'b0);
    xact(2'b00, 32'h0);
    new_req(1, 32'hF500_0028, 4'b0101, 1'b0);
    xact(2'b00, 32'h0);
    rv[1] = 1'b0;
    idle(1);

    // both valid, no lock: alternating grants
    new_req(0, $urandom, 4'b1111, 1'b0);
    new_req(1, $urandom, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      xact(2'b00, $urandom);
      new_req(last_w, $urandom, 4'b0011, 1'b0);
    end

    // r0 holds lock: consecutive grants to r0 while r1 waits, then release
    new_req(0, $urandom, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      xact(2'b00, $urandom);
      new_req(0, $urandom, 4'b0001, 1'b1);
    end
    rlock[0] = 1'b0;
    xact(2'b00, $urandom);
    rv[0] = 1'b0;
    xact(2'b00, $urandom);
    rv = '0;
    idle(2);

    // try-again-later five times: four reissues, then error
    new_req(0, 32'hF500_0040, 4'b0000, 1'b0);
    tick();
    check("retry_owner", sched_owner, 2'b01);
    last_w = 0; lk_held = 1'b0; lk_port = 0;
    for (int t = 0; t <= int'(MAX_RETRY); t++) begin
      check("retry_req", mst_req, 1);
      mst_done = 1'b1; mst_status = 2'b11; mst_rdata = $urandom;
      tick();
      mst_done = 1'b0;
      if (t < int'(MAX_RETRY)) begin
        gap = 0;
        while (!mst_req && gap < 40) begin tick(); gap++; end
        check("retry_gap_ok", (gap >= int'(RETRY_DELAY)) && (gap < 40), 1);
      end
    end
    tick();
    check("retry_ready_early", {r1_ready, r0_ready}, 0);
    tick();
    check("retry_ready", {r1_ready, r0_ready}, 2'b01);
    check("retry_err", r0_err, 1);
    check("retry_noreq", mst_req, 0);
    check("retry_rdata", r0_rdata, mrd[0]);
    rv[0] = 1'b0;
    idle(1);

    // bus timeout and error status: immediate error
    new_req(1, $urandom, 4'b0000, 1'b0);
    xact(2'b10, $urandom);
    new_req(1, $urandom, 4'b1111, 1'b0);
    xact(2'b01, $urandom);
    rv[1] = 1'b0;
    idle(1);

    // randomized mixed traffic
    new_req(0, $urandom, 4'($urandom), 1'b0);
    for (int i = 0; i < 30; i++) begin
      xact(2'($urandom_range(0, 2)), $urandom);
      for (int p = 0; p < 2; p++) begin
        if (p == last_w || !rv[p]) begin
          rv[p] = 1'($urandom);
          if (rv[p]) new_req(p, $urandom, 4'($urandom), ($urandom_range(0, 3) == 0));
        end
      end
      if (rv == 2'b00) new_req($urandom_range(0, 1), $urandom, 4'($urandom), 1'b0);
    end
    rv = '0; rlock = '0;
    idle(2);

    // reset in ISSUE, then pointer back to port 0
    new_req(0, $urandom, 4'b0000, 1'b0);
    tick();
    check("pre_rst_req", mst_req, 1);
    nub_resetn = 1'b0;
    #1;
    check("async_rst_req", mst_req, 0);
    check("async_rst_owner", sched_owner, 0);
    new_req(1, $urandom, 4'b0000, 1'b0);
    tick(); tick();
    check("rst_no_ready", {r1_ready, r0_ready}, 0);
    nub_resetn = 1'b1;
    last_w = 1; lk_held = 1'b0; mrd[0] = '0; mrd[1] = '0;
    xact(2'b00, $urandom);
    rv[0] = 1'b0;
    xact(2'b00, $urandom);
    rv = '0;
    idle(2);

    // no mst_done ever returned
    new_req(0, 32'hF500_0080, 4'b0000, 1'b0);
    tick();
    check("stall_req", mst_req, 1);
`ifdef NUBUS_SCHED_WATCHDOG_EN
    gap = 0;
    while (!mst_abort && gap < 40) begin tick(); gap++; end
    check("wdog_cycles", gap, WDOG_CYCLES);
    check("wdog_req_drop", mst_req, 0);
    tick();
    check("wdog_abort_pulse", mst_abort, 0);
    check("wdog_ready", {r1_ready, r0_ready}, 2'b01);
    check("wdog_err", r0_err, 1);
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (mst_req !== 1'b1 || r0_ready !== 1'b0 || mst_abort !== 1'b0) bad++;
    end
    check("stall_1000", bad, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
